// File: rtl/axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter
//   N-master to 1-slave AXI4 burst arbiter with round-robin fairness per
//   direction. One read and one write transaction can be in flight at a time.
//   With SHARED_RW=1 reads and writes are mutually exclusive (single-port
//   memory behind the slave port), and a read/write tie is broken by a
//   toggling priority bit.
//
// Ports (master vectors are flattened; master i occupies slice [i*W +: W])
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   m_ar*  / m_arready       master read-address channels
//   m_r*   / m_rready        read data; payload broadcast, m_rvalid only to owner
//   m_aw*  / m_awready       master write-address channels
//   m_w*   / m_wready        master write-data channels
//   m_b*   / m_bready        write response; m_bresp broadcast, m_bvalid to owner
//   s_*                      single slave port, directions reversed
//   r_grant, w_grant         one-hot owner of each direction, 0 when idle
// ---------------------------------------------------------------------------
module axi_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter bit SHARED_RW   = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  // master read address
  input  logic [NUM_MASTERS*ADDR_W-1:0]       m_araddr,
  input  logic [NUM_MASTERS*8-1:0]            m_arlen,
  input  logic [NUM_MASTERS*3-1:0]            m_arsize,
  input  logic [NUM_MASTERS*2-1:0]            m_arburst,
  input  logic [NUM_MASTERS-1:0]              m_arvalid,
  output logic [NUM_MASTERS-1:0]              m_arready,
  // master read data
  output logic [DATA_W-1:0]                   m_rdata,
  output logic [1:0]                          m_rresp,
  output logic                                m_rlast,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  input  logic [NUM_MASTERS-1:0]              m_rready,
  // master write address
  input  logic [NUM_MASTERS*ADDR_W-1:0]       m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]            m_awlen,
  input  logic [NUM_MASTERS*2-1:0]            m_awburst,
  input  logic [NUM_MASTERS-1:0]              m_awvalid,
  output logic [NUM_MASTERS-1:0]              m_awready,
  // master write data
  input  logic [NUM_MASTERS*DATA_W-1:0]       m_wdata,
  input  logic [(NUM_MASTERS*DATA_W/8)-1:0]   m_wstrb,
  input  logic [NUM_MASTERS-1:0]              m_wlast,
  input  logic [NUM_MASTERS-1:0]              m_wvalid,
  output logic [NUM_MASTERS-1:0]              m_wready,
  // master write response
  output logic [1:0]                          m_bresp,
  output logic [NUM_MASTERS-1:0]              m_bvalid,
  input  logic [NUM_MASTERS-1:0]              m_bready,
  // slave read address
  output logic [ADDR_W-1:0]                   s_araddr,
  output logic [7:0]                          s_arlen,
  output logic [2:0]                          s_arsize,
  output logic [1:0]                          s_arburst,
  output logic                                s_arvalid,
  input  logic                                s_arready,
  // slave read data
  input  logic [DATA_W-1:0]                   s_rdata,
  input  logic [1:0]                          s_rresp,
  input  logic                                s_rlast,
  input  logic                                s_rvalid,
  output logic                                s_rready,
  // slave write address
  output logic [ADDR_W-1:0]                   s_awaddr,
  output logic [7:0]                          s_awlen,
  output logic [1:0]                          s_awburst,
  output logic                                s_awvalid,
  input  logic                                s_awready,
  // slave write data
  output logic [DATA_W-1:0]                   s_wdata,
  output logic [(DATA_W/8)-1:0]               s_wstrb,
  output logic                                s_wlast,
  output logic                                s_wvalid,
  input  logic                                s_wready,
  // slave write response
  input  logic [1:0]                          s_bresp,
  input  logic                                s_bvalid,
  output logic                                s_bready,
  // grants
  output logic [NUM_MASTERS-1:0]              r_grant,
  output logic [NUM_MASTERS-1:0]              w_grant
);

  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t         r_state, r_state_nxt;
  w_state_t         w_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx;     // index of the current owner
  logic [IDX_W-1:0] rd_ptr, wr_ptr;   // first candidate for the next arbitration
  logic             rw_pri;           // 0: read wins a read/write tie
  logic [IDX_W-1:0] r_pick, w_pick;
  logic             ar_any, aw_any;
  logic             r_go, w_go, r_done, w_done, rw_tie;

  // First requester at or after ptr, wrapping from NUM_MASTERS-1 to 0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign ar_any = |m_arvalid;
  assign aw_any = |m_awvalid;
  assign r_pick = rr_pick(m_arvalid, rd_ptr);
  assign w_pick = rr_pick(m_awvalid, wr_ptr);

  // In shared mode a side may only start while the other side is idle; a
  // simultaneous request from both sides is settled by rw_pri, which flips on
  // every such tie so neither direction can be starved.
  always_comb begin
    rw_tie = SHARED_RW && (r_state == R_IDLE) && (w_state == W_IDLE) && ar_any && aw_any;
    if (SHARED_RW) begin
      r_go = ar_any && (r_state == R_IDLE) && (w_state == W_IDLE) && !(aw_any && rw_pri);
      w_go = aw_any && (w_state == W_IDLE) && (r_state == R_IDLE) && !(ar_any && !rw_pri);
    end else begin
      r_go = ar_any && (r_state == R_IDLE);
      w_go = aw_any && (w_state == W_IDLE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      r_idx   <= '0;
      w_idx   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rw_pri  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      w_state <= w_state_nxt;
      if (r_go)   r_idx  <= r_pick;
      if (w_go)   w_idx  <= w_pick;
      if (r_done) rd_ptr <= next_ptr(r_idx);
      if (w_done) wr_ptr <= next_ptr(w_idx);
      if (rw_tie) rw_pri <= ~rw_pri;
    end
  end

  // Payloads are muxed from the owner index; only valid/ready are gated.
  assign s_araddr  = m_araddr [int'(r_idx)*ADDR_W +: ADDR_W];
  assign s_arlen   = m_arlen  [int'(r_idx)*8      +: 8];
  assign s_arsize  = m_arsize [int'(r_idx)*3      +: 3];
  assign s_arburst = m_arburst[int'(r_idx)*2      +: 2];
  assign s_awaddr  = m_awaddr [int'(w_idx)*ADDR_W +: ADDR_W];
  assign s_awlen   = m_awlen  [int'(w_idx)*8      +: 8];
  assign s_awburst = m_awburst[int'(w_idx)*2      +: 2];
  assign s_wdata   = m_wdata  [int'(w_idx)*DATA_W +: DATA_W];
  assign s_wstrb   = m_wstrb  [int'(w_idx)*STRB_W +: STRB_W];
  assign s_wlast   = m_wlast  [w_idx];

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;
  assign m_bresp = s_bresp;

  assign r_grant = (r_state == R_IDLE) ? '0 : (NUM_MASTERS'(1) << r_idx);
  assign w_grant = (w_state == W_IDLE) ? '0 : (NUM_MASTERS'(1) << w_idx);

  // Read direction: next state and handshake routing. Nothing is forwarded in
  // R_IDLE, so there is no combinational path from m_arvalid to m_arready.
  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    r_state_nxt = r_state;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m_arready   = '0;
    m_rvalid    = '0;
    r_done      = 1'b0;
    unique case (r_state)
      R_IDLE: if (r_go) r_state_nxt = R_ADDR;
      R_ADDR: begin
        s_arvalid        = m_arvalid[r_idx];
        m_arready[r_idx] = s_arready;
        if (m_arvalid[r_idx] && s_arready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_rready        = m_rready[r_idx];
        m_rvalid[r_idx] = s_rvalid;
        if (s_rvalid && m_rready[r_idx] && s_rlast) begin
          r_done      = 1'b1;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write direction: AW, then W beats until wlast, then B.
  always_comb begin
    w_state_nxt = w_state;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    m_awready   = '0;
    m_wready    = '0;
    m_bvalid    = '0;
    w_done      = 1'b0;
    unique case (w_state)
      W_IDLE: if (w_go) w_state_nxt = W_ADDR;
      W_ADDR: begin
        s_awvalid        = m_awvalid[w_idx];
        m_awready[w_idx] = s_awready;
        if (m_awvalid[w_idx] && s_awready) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_wvalid        = m_wvalid[w_idx];
        m_wready[w_idx] = s_wready;
        if (m_wvalid[w_idx] && s_wready && m_wlast[w_idx]) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_bready        = m_bready[w_idx];
        m_bvalid[w_idx] = s_bvalid;
        if (s_bvalid && m_bready[w_idx]) begin
          w_done      = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rr_arbiter
//   Directed bench for axi_rr_arbiter. Two instances share the same master
//   and slave stimulus: dut_a (4 masters, shared read/write) and dut_b
//   (2 masters, independent read/write, lower two master slices). Each
//   scenario starts from reset and checks only the instance it targets.
//   Inputs change just after the falling edge; outputs are sampled 1 time
//   unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side stimulus, sized for 4 masters
  logic [127:0] m_araddr;  logic [31:0] m_arlen;  logic [11:0] m_arsize;
  logic [7:0]   m_arburst; logic [3:0]  m_arvalid; logic [3:0] m_rready;
  logic [127:0] m_awaddr;  logic [31:0] m_awlen;  logic [7:0]  m_awburst;
  logic [3:0]   m_awvalid; logic [255:0] m_wdata; logic [31:0] m_wstrb;
  logic [3:0]   m_wlast;   logic [3:0]  m_wvalid; logic [3:0]  m_bready;
  // slave-side stimulus
  logic s_arready, s_rlast, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [63:0] s_rdata; logic [1:0] s_rresp, s_bresp;

  // dut_a outputs
  logic [3:0]  a_m_arready, a_m_rvalid, a_m_awready, a_m_wready, a_m_bvalid;
  logic [63:0] a_m_rdata;   logic [1:0] a_m_rresp, a_m_bresp; logic a_m_rlast;
  logic [31:0] a_s_araddr, a_s_awaddr; logic [7:0] a_s_arlen, a_s_awlen;
  logic [2:0]  a_s_arsize;  logic [1:0] a_s_arburst, a_s_awburst;
  logic        a_s_arvalid, a_s_rready, a_s_awvalid, a_s_wlast, a_s_wvalid, a_s_bready;
  logic [63:0] a_s_wdata;   logic [7:0] a_s_wstrb;
  logic [3:0]  a_r_grant, a_w_grant;
  // dut_b outputs
  logic [1:0]  b_m_arready, b_m_rvalid, b_m_awready, b_m_wready, b_m_bvalid;
  logic [63:0] b_m_rdata;   logic [1:0] b_m_rresp, b_m_bresp; logic b_m_rlast;
  logic [31:0] b_s_araddr, b_s_awaddr; logic [7:0] b_s_arlen, b_s_awlen;
  logic [2:0]  b_s_arsize;  logic [1:0] b_s_arburst, b_s_awburst;
  logic        b_s_arvalid, b_s_rready, b_s_awvalid, b_s_wlast, b_s_wvalid, b_s_bready;
  logic [63:0] b_s_wdata;   logic [7:0] b_s_wstrb;
  logic [1:0]  b_r_grant, b_w_grant;

  axi_rr_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(64), .SHARED_RW(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(a_m_arready),
    .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rlast(a_m_rlast), .m_rvalid(a_m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awvalid(m_awvalid),
    .m_awready(a_m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(a_m_wready),
    .m_bresp(a_m_bresp), .m_bvalid(a_m_bvalid), .m_bready(m_bready),
    .s_araddr(a_s_araddr), .s_arlen(a_s_arlen), .s_arsize(a_s_arsize), .s_arburst(a_s_arburst),
    .s_arvalid(a_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(a_s_rready),
    .s_awaddr(a_s_awaddr), .s_awlen(a_s_awlen), .s_awburst(a_s_awburst),
    .s_awvalid(a_s_awvalid), .s_awready(s_awready),
    .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wlast(a_s_wlast), .s_wvalid(a_s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(a_s_bready),
    .r_grant(a_r_grant), .w_grant(a_w_grant)
  );

  axi_rr_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(64), .SHARED_RW(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr[63:0]), .m_arlen(m_arlen[15:0]), .m_arsize(m_arsize[5:0]),
    .m_arburst(m_arburst[3:0]), .m_arvalid(m_arvalid[1:0]), .m_arready(b_m_arready),
    .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rlast(b_m_rlast), .m_rvalid(b_m_rvalid),
    .m_rready(m_rready[1:0]),
    .m_awaddr(m_awaddr[63:0]), .m_awlen(m_awlen[15:0]), .m_awburst(m_awburst[3:0]),
    .m_awvalid(m_awvalid[1:0]), .m_awready(b_m_awready),
    .m_wdata(m_wdata[127:0]), .m_wstrb(m_wstrb[15:0]), .m_wlast(m_wlast[1:0]),
    .m_wvalid(m_wvalid[1:0]), .m_wready(b_m_wready),
    .m_bresp(b_m_bresp), .m_bvalid(b_m_bvalid), .m_bready(m_bready[1:0]),
    .s_araddr(b_s_araddr), .s_arlen(b_s_arlen), .s_arsize(b_s_arsize), .s_arburst(b_s_arburst),
    .s_arvalid(b_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(b_s_rready),
    .s_awaddr(b_s_awaddr), .s_awlen(b_s_awlen), .s_awburst(b_s_awburst),
    .s_awvalid(b_s_awvalid), .s_awready(s_awready),
    .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wlast(b_s_wlast), .s_wvalid(b_s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(b_s_bready),
    .r_grant(b_r_grant), .w_grant(b_w_grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_awlen = '0; m_awburst = '0; m_awvalid = '0;
    m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 1'b0; s_rlast = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_bresp = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle of the read burst on dut_b (2 masters, M0 alone).
  typedef struct {
    logic [1:0]  arvalid;
    logic [1:0]  rready;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [63:0] rdata;
    logic [1:0]  x_rgrant;
    logic        x_sarvalid;
    logic [1:0]  x_marready;
    logic [1:0]  x_mrvalid;
    logic        x_srready;
  } rd_vec_t;

  rd_vec_t    rd_vecs [0:8];
  logic [3:0] rr_seen [0:4];
  logic [3:0] rr_exp  [0:4];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int         n_seen;
    logic [3:0] prev;

    // ---------------- reset state, with busy-looking inputs ----------------
    clear_inputs();
    rst = 1'b1;
    m_arvalid = '1; m_awvalid = '1; m_wvalid = '1; m_rready = '1; m_bready = '1;
    s_arready = 1'b1; s_rvalid = 1'b1; s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    @(negedge clk);
    #1;
    check("rst a grants", 64'({a_r_grant, a_w_grant}), 64'(0));
    check("rst b grants", 64'({b_r_grant, b_w_grant}), 64'(0));
    check("rst a m ready/valid",
          64'({a_m_arready, a_m_rvalid, a_m_awready, a_m_wready, a_m_bvalid}), 64'(0));
    check("rst b m ready/valid",
          64'({b_m_arready, b_m_rvalid, b_m_awready, b_m_wready, b_m_bvalid}), 64'(0));
    check("rst a s valid/ready",
          64'({a_s_arvalid, a_s_rready, a_s_awvalid, a_s_wvalid, a_s_bready}), 64'(0));
    check("rst b s valid/ready",
          64'({b_s_arvalid, b_s_rready, b_s_awvalid, b_s_wvalid, b_s_bready}), 64'(0));

    // ---------------- 1: single 4-beat read on 2 masters (table) ----------------
    //            arv    rrdy   ardy  rv    rlast rdata             grant  sarv  marr   mrv    srr
    rd_vecs[0] = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0,            2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
    rd_vecs[1] = '{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0,            2'b01, 1'b1, 2'b01, 2'b00, 1'b0};
    rd_vecs[2] = '{2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 64'h1111_0000_D0, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1};
    rd_vecs[3] = '{2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 64'h2222_0000_D1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0};
    rd_vecs[4] = '{2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 64'h2222_0000_D1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1};
    rd_vecs[5] = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 64'h0,            2'b01, 1'b0, 2'b00, 2'b00, 1'b1};
    rd_vecs[6] = '{2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 64'h3333_0000_D2, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1};
    rd_vecs[7] = '{2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 64'h4444_0000_D3, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1};
    rd_vecs[8] = '{2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 64'h0,            2'b00, 1'b0, 2'b00, 2'b00, 1'b0};

    apply_reset();
    m_araddr[31:0] = 32'h8000_0000;
    m_arlen[7:0]   = 8'd3;
    for (int i = 0; i < 9; i++) begin
      m_arvalid[1:0] = rd_vecs[i].arvalid;
      m_rready[1:0]  = rd_vecs[i].rready;
      s_arready      = rd_vecs[i].arready;
      s_rvalid       = rd_vecs[i].rvalid;
      s_rlast        = rd_vecs[i].rlast;
      s_rdata        = rd_vecs[i].rdata;
      #1;
      check($sformatf("t1 v%0d r_grant", i),   64'(b_r_grant),   64'(rd_vecs[i].x_rgrant));
      check($sformatf("t1 v%0d s_arvalid", i), 64'(b_s_arvalid), 64'(rd_vecs[i].x_sarvalid));
      check($sformatf("t1 v%0d m_arready", i), 64'(b_m_arready), 64'(rd_vecs[i].x_marready));
      check($sformatf("t1 v%0d m_rvalid", i),  64'(b_m_rvalid),  64'(rd_vecs[i].x_mrvalid));
      check($sformatf("t1 v%0d s_rready", i),  64'(b_s_rready),  64'(rd_vecs[i].x_srready));
      if (rd_vecs[i].x_sarvalid) begin
        check($sformatf("t1 v%0d s_araddr", i), 64'(b_s_araddr), 64'(32'h8000_0000));
        check($sformatf("t1 v%0d s_arlen", i),  64'(b_s_arlen),  64'(8'd3));
      end
      if (rd_vecs[i].x_mrvalid != 2'b00) begin
        check($sformatf("t1 v%0d m_rdata", i), b_m_rdata, rd_vecs[i].rdata);
        check($sformatf("t1 v%0d m_rlast", i), 64'(b_m_rlast), 64'(rd_vecs[i].rlast));
      end
      @(negedge clk);
    end

    // ---------------- 2: 4 masters always requesting, single-beat reads ----------------
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int k = 0; k < 5; k++) rr_seen[k] = 4'b0000;
    apply_reset();
    m_arvalid = 4'hF; m_rready = 4'hF;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
    n_seen = 0;
    prev   = 4'b0000;
    for (int c = 0; c < 40 && n_seen < 5; c++) begin
      #1;
      if (prev == 4'b0000 && a_r_grant != 4'b0000) begin
        rr_seen[n_seen] = a_r_grant;
        n_seen++;
      end
      prev = a_r_grant;
      @(negedge clk);
    end
    check("t2 grants observed", 64'(n_seen), 64'(5));
    for (int k = 0; k < 5; k++)
      check($sformatf("t2 grant #%0d", k), 64'(rr_seen[k]), 64'(rr_exp[k]));

    // ---------------- 3: shared mode, read/write tie ----------------
    apply_reset();
    m_araddr[31:0] = 32'h0000_0100;
    m_arvalid = 4'b0001; m_awvalid = 4'b0010;
    #1;
    check("t3 c0 grants idle", 64'({a_r_grant, a_w_grant}), 64'(0));
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    check("t3 c1 read wins tie", 64'(a_r_grant), 64'(4'b0001));
    check("t3 c1 write held", 64'({a_w_grant, a_s_awvalid}), 64'(0));
    check("t3 c1 s_arvalid", 64'(a_s_arvalid), 64'(1));
    @(negedge clk);
    m_arvalid = 4'b0000; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 4'b0001;
    #1;
    check("t3 c2 m_rvalid", 64'(a_m_rvalid), 64'(4'b0001));
    check("t3 c2 write held during read", 64'(a_w_grant), 64'(0));
    @(negedge clk);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    check("t3 c3 both idle", 64'({a_r_grant, a_w_grant}), 64'(0));
    @(negedge clk);
    s_awready = 1'b1;
    #1;
    check("t3 c4 write granted after read", 64'(a_w_grant), 64'(4'b0010));
    check("t3 c4 s_awvalid", 64'(a_s_awvalid), 64'(1));
    @(negedge clk);
    m_awvalid = 4'b0000; s_awready = 1'b0;
    m_wvalid = 4'b0010; m_wlast = 4'b0010; s_wready = 1'b1;
    #1;
    check("t3 c5 s_wvalid", 64'(a_s_wvalid), 64'(1));
    @(negedge clk);
    m_wvalid = 4'b0000; m_wlast = 4'b0000; s_wready = 1'b0;
    s_bvalid = 1'b1; m_bready = 4'b0010;
    #1;
    check("t3 c6 m_bvalid", 64'(a_m_bvalid), 64'(4'b0010));
    @(negedge clk);
    s_bvalid = 1'b0; m_bready = 4'b0000;
    m_arvalid = 4'b0001; m_awvalid = 4'b0010;
    #1;
    check("t3 c7 idle before 2nd tie", 64'({a_r_grant, a_w_grant}), 64'(0));
    @(negedge clk);
    #1;
    check("t3 c8 write wins 2nd tie", 64'(a_w_grant), 64'(4'b0010));
    check("t3 c8 read held", 64'({a_r_grant, a_s_arvalid}), 64'(0));

    // ---------------- 4: independent mode, same stimulus ----------------
    apply_reset();
    m_arvalid = 4'b0001; m_awvalid = 4'b0010;
    #1;
    check("t4 c0 grants idle", 64'({b_r_grant, b_w_grant}), 64'(0));
    @(negedge clk);
    #1;
    check("t4 c1 s_arvalid&s_awvalid", 64'({b_s_arvalid, b_s_awvalid}), 64'(2'b11));
    check("t4 c1 grants", 64'({b_r_grant, b_w_grant}), 64'(4'b01_10));
    @(negedge clk);
    s_arready = 1'b1; s_awready = 1'b1;
    #1;
    check("t4 c2 addr readies", 64'({b_m_arready, b_m_awready}), 64'(4'b01_10));
    @(negedge clk);
    m_arvalid = 4'b0000; m_awvalid = 4'b0000; s_arready = 1'b0; s_awready = 1'b0;
    m_wvalid = 4'b0010; m_wlast = 4'b0010; s_wready = 1'b1;
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 4'b0001;
    #1;
    check("t4 c3 m_rvalid", 64'(b_m_rvalid), 64'(2'b01));
    check("t4 c3 m_wready", 64'(b_m_wready), 64'(2'b10));
    @(negedge clk);
    m_wvalid = 4'b0000; m_wlast = 4'b0000; s_wready = 1'b0;
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 4'b0000;
    #1;
    check("t4 c4 read done, write in resp", 64'({b_r_grant, b_w_grant}), 64'(4'b00_10));
    check("t4 c4 no bvalid yet", 64'(b_m_bvalid), 64'(0));
    @(negedge clk);
    s_bvalid = 1'b1; m_bready = 4'b0010;
    #1;
    check("t4 c5 m_bvalid/s_bready", 64'({b_m_bvalid, b_s_bready}), 64'(3'b10_1));
    @(negedge clk);
    s_bvalid = 1'b0; m_bready = 4'b0000;
    #1;
    check("t4 c6 w_grant clear", 64'(b_w_grant), 64'(0));

    // ---------------- 5: 2-beat write from M1 with strobes ----------------
    apply_reset();
    m_awaddr[63:32] = 32'h0000_1000; m_awlen[15:8] = 8'd1;
    m_awvalid = 4'b0010; s_awready = 1'b1;
    #1;
    check("t5 c0 no comb ready", 64'({b_w_grant, b_m_awready}), 64'(0));
    @(negedge clk);
    #1;
    check("t5 c1 w_grant", 64'(b_w_grant), 64'(2'b10));
    check("t5 c1 s_awaddr", 64'(b_s_awaddr), 64'(32'h0000_1000));
    check("t5 c1 s_awlen", 64'(b_s_awlen), 64'(8'd1));
    check("t5 c1 m_awready", 64'(b_m_awready), 64'(2'b10));
    @(negedge clk);
    m_awvalid = 4'b0000; s_awready = 1'b0;
    m_wvalid = 4'b0011; s_wready = 1'b1;
    m_wdata[63:0]  = 64'hDEAD_DEAD_DEAD_DEAD; m_wstrb[7:0]  = 8'hFF;
    m_wdata[127:64] = 64'hA1A1_0000_0000_0001; m_wstrb[15:8] = 8'h0F;
    m_wlast = 4'b0001;
    #1;
    check("t5 beat1 s_wdata", b_s_wdata, 64'hA1A1_0000_0000_0001);
    check("t5 beat1 s_wstrb", 64'(b_s_wstrb), 64'(8'h0F));
    check("t5 beat1 s_wlast", 64'(b_s_wlast), 64'(0));
    check("t5 beat1 m_wready", 64'(b_m_wready), 64'(2'b10));
    @(negedge clk);
    m_wdata[127:64] = 64'hA2A2_0000_0000_0002; m_wstrb[15:8] = 8'hFF;
    m_wlast = 4'b0011;
    #1;
    check("t5 beat2 s_wdata", b_s_wdata, 64'hA2A2_0000_0000_0002);
    check("t5 beat2 s_wstrb", 64'(b_s_wstrb), 64'(8'hFF));
    check("t5 beat2 s_wlast", 64'(b_s_wlast), 64'(1));
    @(negedge clk);
    m_wvalid = 4'b0000; m_wlast = 4'b0000; s_wready = 1'b0;
    #1;
    check("t5 resp wait", 64'({b_w_grant, b_m_bvalid, b_s_wvalid}), 64'(5'b10_00_0));
    @(negedge clk);
    s_bvalid = 1'b1; s_bresp = 2'b10; m_bready = 4'b0010;
    #1;
    check("t5 m_bvalid", 64'(b_m_bvalid), 64'(2'b10));
    check("t5 m_bresp", 64'(b_m_bresp), 64'(2'b10));
    @(negedge clk);
    s_bvalid = 1'b0; m_bready = 4'b0000;
    #1;
    check("t5 w_grant clear", 64'({b_w_grant, b_m_bvalid}), 64'(0));

    // ---------------- 6: reset in the middle of a 4-beat read ----------------
    apply_reset();
    m_araddr[31:0] = 32'h0000_2000; m_arlen[7:0] = 8'd3;
    m_arvalid = 4'b0001; s_arready = 1'b1;
    @(negedge clk);
    #1;
    check("t6 granted", 64'(b_r_grant), 64'(2'b01));
    @(negedge clk);
    m_arvalid = 4'b0000; s_arready = 1'b0;
    s_rvalid = 1'b1; m_rready = 4'b0001;
    #1;
    check("t6 beat1 m_rvalid", 64'(b_m_rvalid), 64'(2'b01));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6 rst immediate", 64'({b_r_grant, b_m_rvalid, b_s_rready, b_s_arvalid, b_m_arready}),
          64'(0));
    @(negedge clk);
    #1;
    check("t6 rst next cycle", 64'({b_r_grant, b_m_rvalid, b_s_rready, b_s_arvalid, b_m_arready}),
          64'(0));
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    m_araddr[31:0] = 32'h0000_3000;
    m_arvalid = 4'b0001; s_arready = 1'b1;
    #1;
    check("t6 after release idle", 64'(b_r_grant), 64'(0));
    @(negedge clk);
    #1;
    check("t6 new AR granted", 64'({b_r_grant, b_s_arvalid}), 64'(3'b01_1));
    check("t6 new AR addr", 64'(b_s_araddr), 64'(32'h0000_3000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
